// File: rtl/instr_encoder_writer_if.sv
// Loader-to-encoder field bundle, instruction RAM write port and status outputs.
// The loader side uses the master modport and the encoder uses the slave modport.
interface instr_encoder_writer_if #(
    parameter int ARQ = 16,
    parameter int AW  = 8
);
    logic            start;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_opcode;
    logic [2:0]      in_srcdest;
    logic [2:0]      in_src1;
    logic [2:0]      in_src2;
    logic [12:0]     in_addr;
    logic [9:0]      in_imm;
    logic            in_last;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [ARQ-1:0]  mem_wdata;
    logic            busy;
    logic            done;
    logic            full;
    logic            err_target;
    logic [AW:0]     word_count;

    modport master (
        output start, in_valid, in_opcode, in_srcdest, in_src1, in_src2,
               in_addr, in_imm, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, full,
               err_target, word_count
    );

    modport slave (
        input  start, in_valid, in_opcode, in_srcdest, in_src1, in_src2,
               in_addr, in_imm, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, full,
               err_target, word_count
    );
endinterface

// File: rtl/instr_encoder_writer.sv
// Packs decoded instruction fields into 16-bit ASIP words and writes them
// sequentially into instruction RAM, one registered write per accepted bundle.
module instr_encoder_writer #(
    parameter int ARQ   = 16,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_encoder_writer_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    logic [1:0]     r_state;
    logic [AW-1:0]  r_wr_ptr;
    logic           r_mem_we;
    logic [AW-1:0]  r_mem_addr;
    logic [ARQ-1:0] r_mem_wdata;
    logic           r_done;
    logic           r_full;
    logic           r_err_target;
    logic [AW:0]    r_word_count;

    logic           w_accept;
    logic           w_at_end;
    logic           w_bad_target;
    logic [ARQ-1:0] w_word;

    assign w_accept     = bus.in_valid && (r_state == S_RUN);
    assign w_at_end     = (r_wr_ptr == AW'(DEPTH - 1));
    assign w_bad_target = ((bus.in_opcode == 3'b101) || (bus.in_opcode == 3'b110)) &&
                          (32'(bus.in_addr) >= 32'(DEPTH));

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_word = '0;
        case (bus.in_opcode)
            3'b010, 3'b100: w_word = {bus.in_opcode, bus.in_srcdest, bus.in_src1, bus.in_src2, 4'b0};
            3'b001, 3'b011: w_word = {bus.in_opcode, bus.in_srcdest, bus.in_src1, 7'b0};
            3'b101, 3'b110: w_word = {bus.in_opcode, bus.in_addr};
            default:        w_word = {bus.in_opcode, bus.in_srcdest, bus.in_imm};
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_done       <= 1'b0;
            r_full       <= 1'b0;
            r_err_target <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_mem_we <= w_accept;
            r_done   <= w_accept && (bus.in_last || w_at_end);
            if (w_accept) begin
                r_mem_addr   <= r_wr_ptr;
                r_mem_wdata  <= w_word;
                r_wr_ptr     <= r_wr_ptr + 1'b1;
                r_word_count <= r_word_count + 1'b1;
                if (w_bad_target) begin
                    r_err_target <= 1'b1;
                end
                if (bus.in_last) begin
                    r_state <= S_IDLE;
                end else if (w_at_end) begin
                    r_state <= S_FULL;
                    r_full  <= 1'b1;
                end
            end else if (bus.start && (r_state != S_RUN)) begin
                // A write already on the port still completes; only the load bookkeeping restarts.
                r_state      <= S_RUN;
                r_wr_ptr     <= '0;
                r_word_count <= '0;
                r_full       <= 1'b0;
                r_err_target <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = (r_state == S_RUN);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.done       = r_done;
    assign bus.full       = r_full;
    assign bus.err_target = r_err_target;
    assign bus.word_count = r_word_count;

endmodule
